// File: rtl/plic_claim_master_if.sv
// TileLink-UL A/D channel bundle between the claim master and the PLIC slave port.
interface plic_claim_master_if;
    localparam int unsigned ADDR_W = 28;
    localparam int unsigned SRC_W  = 11;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [SRC_W-1:0]  a_source;
    logic [ADDR_W-1:0] a_address;
    logic [MASK_W-1:0] a_mask;
    logic [DATA_W-1:0] a_data;
    logic              a_corrupt;

    logic              d_valid;
    logic              d_ready;
    logic [2:0]        d_opcode;
    logic [1:0]        d_size;
    logic [SRC_W-1:0]  d_source;
    logic [DATA_W-1:0] d_data;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_size, d_source, d_data,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_size, d_source, d_data,
        input  d_ready
    );
endinterface

// File: rtl/plic_claim_master.sv
// Claims a PLIC interrupt with a TL Get, hands the ID to a consumer, then completes it with a PutFullData.
module plic_claim_master #(
    parameter logic [27:0] CLAIM_ADDR = 28'h0200004,
    parameter logic [10:0] SOURCE_ID  = 11'd0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      irq_in,
    plic_claim_master_if.master       tl,
    output logic                      svc_valid,
    input  logic                      svc_ready,
    output logic [31:0]               svc_id,
    output logic [7:0]                spurious_cnt,
    output logic                      proto_err
);
    localparam int unsigned ID_W      = 32;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned CNT_W     = 8;
    localparam logic [2:0]  OP_GET    = 3'd4;
    localparam logic [2:0]  OP_PUT    = 3'd0;
    localparam logic [2:0]  OP_ACKD   = 3'd1;
    localparam logic [2:0]  OP_ACK    = 3'd0;
    localparam logic        UPPER     = CLAIM_ADDR[2];

    typedef enum logic [2:0] {IDLE, CLAIM_A, CLAIM_D, SERVICE, COMP_A, COMP_D} state_e;

    state_e              state_q, state_d;
    logic                a_valid_q, a_valid_d;
    logic [2:0]          a_opcode_q, a_opcode_d;
    logic [DATA_W-1:0]   a_data_q, a_data_d;
    logic                d_ready_q, d_ready_d;
    logic                svc_valid_q, svc_valid_d;
    logic [ID_W-1:0]     svc_id_q, svc_id_d;
    logic [CNT_W-1:0]    spur_q, spur_d;
    logic                perr_q, perr_d;

    logic                a_hs, d_hs, svc_hs, d_src_ok;
    logic [ID_W-1:0]     d_lane;
    logic                unused_d;

    // Fields that never change between Get and Put.
    assign tl.a_param   = 3'd0;
    assign tl.a_size    = 2'd2;
    assign tl.a_source  = SOURCE_ID;
    assign tl.a_address = CLAIM_ADDR;
    assign tl.a_mask    = UPPER ? 8'hF0 : 8'h0F;
    assign tl.a_corrupt = 1'b0;

    assign tl.a_valid   = a_valid_q;
    assign tl.a_opcode  = a_opcode_q;
    assign tl.a_data    = a_data_q;
    assign tl.d_ready   = d_ready_q;
    assign svc_valid    = svc_valid_q;
    assign svc_id       = svc_id_q;
    assign spurious_cnt = spur_q;
    assign proto_err    = perr_q;

    assign unused_d = ^tl.d_size;

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        svc_id_d = svc_id_q;
        spur_d   = spur_q;
        perr_d   = perr_q;

        a_hs     = a_valid_q && tl.a_ready;
        d_hs     = tl.d_valid && d_ready_q;
        svc_hs   = svc_valid_q && svc_ready;
        d_src_ok = (tl.d_source == SOURCE_ID);
        d_lane   = UPPER ? tl.d_data[63:32] : tl.d_data[31:0];

        case (state_q)
            IDLE:    if (irq_in) state_d = CLAIM_A;
            CLAIM_A: if (a_hs) state_d = CLAIM_D;
            CLAIM_D: begin
                if (d_hs) begin
                    if ((tl.d_opcode == OP_ACKD) && d_src_ok) begin
                        if (d_lane == '0) begin
                            if (spur_q != 8'hFF) spur_d = CNT_W'(spur_q + 8'd1);
                            state_d = IDLE;
                        end else begin
                            svc_id_d = d_lane;
                            state_d  = SERVICE;
                        end
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            SERVICE: if (svc_hs) state_d = COMP_A;
            COMP_A:  if (a_hs) state_d = COMP_D;
            COMP_D: begin
                if (d_hs) begin
                    if ((tl.d_opcode == OP_ACK) && d_src_ok) begin
                        svc_id_d = '0;
                        state_d  = IDLE;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        a_valid_d   = (state_d == CLAIM_A) || (state_d == COMP_A);
        a_opcode_d  = (state_d == COMP_A) ? OP_PUT : OP_GET;
        if (state_d == COMP_A)
            a_data_d = UPPER ? {svc_id_d, 32'h0} : {32'h0, svc_id_d};
        else
            a_data_d = '0;
        d_ready_d   = (state_d == CLAIM_D) || (state_d == COMP_D);
        svc_valid_d = (state_d == SERVICE);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_valid_q   <= 1'b0;
            a_opcode_q  <= OP_GET;
            a_data_q    <= '0;
            d_ready_q   <= 1'b0;
            svc_valid_q <= 1'b0;
            svc_id_q    <= '0;
            spur_q      <= '0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_valid_q   <= a_valid_d;
            a_opcode_q  <= a_opcode_d;
            a_data_q    <= a_data_d;
            d_ready_q   <= d_ready_d;
            svc_valid_q <= svc_valid_d;
            svc_id_q    <= svc_id_d;
            spur_q      <= spur_d;
            perr_q      <= perr_d;
        end
    end
endmodule

// File: doc/plic_claim_master.md
# plic_claim_master

TileLink-UL initiator that services a PLIC interrupt context on behalf of a hart-side consumer. It watches one PLIC interrupt output and reads the context's claim register with a Get. It hands the claimed source ID to the consumer over a valid/ready handshake, then writes the ID back to the same register with a PutFullData to signal completion. It drives the A channel and sinks the D channel of the PLIC's TL slave port, at the same 28-bit address, 11-bit source and 64-bit data widths.

## Interface
- CLAIM_ADDR, 28'h0200004: byte address of the context's claim/complete register; 4-byte aligned.
- SOURCE_ID, 11'd0: TL source placed on every A beat.
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset.
- irq_in  input  1  level interrupt from PLIC context output.
- a_valid  output  1  A-channel valid.
- a_ready  input  1  A-channel ready.
- a_opcode  output  3  4 = Get, 0 = PutFullData.
- a_param  output  3  always 0.
- a_size  output  2  always 2 (4 bytes).
- a_source  output  11  SOURCE_ID.
- a_address  output  28  CLAIM_ADDR.
- a_mask  output  8  8'hF0 if CLAIM_ADDR[2], else 8'h0F.
- a_data  output  64  {id,32'h0} if CLAIM_ADDR[2], else {32'h0,id}; 0 on Get.
- a_corrupt  output  1  always 0.
- d_valid  input  1  D-channel valid.
- d_ready  output  1  D-channel ready.
- d_opcode  input  3  1 = AccessAckData, 0 = AccessAck.
- d_size  input  2  ignored.
- d_source  input  11  checked against SOURCE_ID.
- d_data  input  64  claim data; lane chosen by CLAIM_ADDR[2].
- svc_valid  output  1  claimed ID available.
- svc_ready  input  1  consumer has finished servicing; triggers complete.
- svc_id  output  32  claimed source ID, stable while svc_valid.
- spurious_cnt  output  8  saturating count of claims returning ID 0.
- proto_err  output  1  sticky; set on an unexpected D opcode or source.

## Operation
- FSM states: IDLE, CLAIM_A, CLAIM_D, SERVICE, COMP_A, COMP_D.
- IDLE: if irq_in is sampled 1, go to CLAIM_A.
- CLAIM_A: a_valid=1 with the Get fields. Advance to CLAIM_D on a_valid&&a_ready.
- CLAIM_D: d_ready=1. On a D beat with d_opcode==1 and d_source==SOURCE_ID, capture id from the selected 32-bit lane.
  - id==0: spurious_cnt increments, saturating at 255; go to IDLE.
  - id!=0: load svc_id and go to SERVICE.
- SERVICE: svc_valid=1. On svc_valid&&svc_ready go to COMP_A.
- COMP_A: a_valid=1 with PutFullData carrying svc_id. Advance to COMP_D on handshake.
- COMP_D: d_ready=1. A beat with d_opcode==0 and matching source goes to IDLE; svc_id clears to 0.
- Bad D beat in CLAIM_D or COMP_D (wrong opcode or source): the beat is consumed. proto_err is set and the FSM stays in the current state awaiting a valid response. proto_err clears only on reset.
- irq_in is ignored outside IDLE. irq_in still high on return to IDLE starts a new claim.
- A-channel fields are registered. They are stable and a_valid is never withdrawn until the handshake completes.
- d_ready is 0 in IDLE, CLAIM_A, SERVICE and COMP_A. D beats in those states are not accepted.

## Timing
- Reset values: a_valid=0, d_ready=0, svc_valid=0, svc_id=0, spurious_cnt=0, proto_err=0, state IDLE. All other A fields show their Get encoding.
- irq_in sampled 1 at edge N puts a_valid=1 in cycle N+1.
- D acceptance at edge M updates svc_valid/svc_id, or IDLE and spurious_cnt, at M+1.
- svc handshake at edge K puts the Put a_valid=1 at K+1.
- Minimum claim-to-complete with zero-wait slave and consumer: 6 cycles IDLE→IDLE.
- Same-edge D response and svc_ready cannot collide; they occur in distinct states.
- Reset mid-transaction aborts immediately with all outputs at reset values. The PLIC may retain an outstanding claim; software recovery is out of scope.

## Test plan
- irq_in=1, slave returns AccessAckData with d_data=64'h0000_0005_0000_0000 (CLAIM_ADDR[2]=1), svc_ready after 3 cycles.
  - Required: Get with mask F0, then svc_id=5, then Put with a_data=64'h0000_0005_0000_0000, mask F0, then IDLE.
- Claim returns 0: no svc_valid, spurious_cnt=1, return to IDLE. 300 spurious claims leave spurious_cnt=255.
- a_ready held low 10 cycles: a_valid and all A fields stay constant throughout; a single Get is issued.
- D beat with d_source=7 during CLAIM_D: proto_err=1, FSM stays in CLAIM_D, then a correct beat completes normally.
- Reset asserted in SERVICE with svc_id=9: svc_valid=0, svc_id=0 immediately; after deassert with irq_in=1, a fresh Get is issued.
- irq_in remains 1 after completion: a second Get is issued one cycle after reaching IDLE.
